// File: rtl/word_align_pkg.sv
// Shared constants and FSM state encodings for the word alignment controller.
package word_align_pkg;

  localparam int WORD_W      = 8;
  localparam int OFFSET_W    = 3;
  localparam int ATTEMPT_MAX = 15;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_MANUAL = 3'd1;
  localparam state_t ST_SEARCH = 3'd2;
  localparam state_t ST_LOCKED = 3'd3;
  localparam state_t ST_FAIL   = 3'd4;

endpackage

// File: rtl/word_align_shifter.sv
// Bit-slip datapath: picks an 8-bit window from {prev_word, data_in}, 1-cycle registered output.
// No backpressure; cand_sel is combinational so the FSM compares the word as it arrives.
module word_align_shifter
  import word_align_pkg::*;
(
  input  logic                clk160,
  input  logic                rstb,
  input  logic [WORD_W-1:0]   data_in,
  input  logic                data_valid,
  input  logic [OFFSET_W-1:0] offset,
  output logic [WORD_W-1:0]   cand_sel,
  output logic [WORD_W-1:0]   data_out,
  output logic                data_out_valid
);

  logic [WORD_W-1:0]   prev_q;
  logic [WORD_W-1:0]   data_out_q;
  logic                data_out_valid_q;
  logic [2*WORD_W-1:0] cat;
  logic [2*WORD_W-1:0] cat_sh;

  // Offset k takes cat[15-k:8-k]; offset 0 is the previous word untouched.
  assign cat      = {prev_q, data_in};
  assign cat_sh   = cat << offset;
  assign cand_sel = cat_sh[2*WORD_W-1:WORD_W];

  always_ff @(posedge clk160) begin
    if (!rstb) begin
      prev_q           <= '0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
    end else begin
      if (data_valid) prev_q <= data_in;
      data_out_q       <= cand_sel;
      data_out_valid_q <= data_valid;
    end
  end

  assign data_out       = data_out_q;
  assign data_out_valid = data_out_valid_q;

endmodule

// File: rtl/word_align_ctrl.sv
// Word alignment FSM: auto search / manual offset, lock tracking; data_out one cycle after data_in, no backpressure.
// Optional sync_err_cnt output when WORD_ALIGN_ERRCNT_EN is defined.
module word_align_ctrl
  import word_align_pkg::*;
#(
  parameter int LOCK_COUNT     = 16,
  parameter int UNLOCK_COUNT   = 4,
  parameter int SEARCH_TIMEOUT = 64
) (
  input  logic                clk160,
  input  logic                rstb,
  input  logic [WORD_W-1:0]   data_in,
  input  logic                data_valid,
  input  logic                delay_ready,
  input  logic                align_mode,
  input  logic [OFFSET_W-1:0] manual_offset,
  input  logic [WORD_W-1:0]   sync_pattern,
  input  logic                track_en,
  input  logic                restart,
  output logic [WORD_W-1:0]   data_out,
  output logic                data_out_valid,
  output logic [OFFSET_W-1:0] offset,
  output logic                aligned,
  output logic                align_fail,
`ifdef WORD_ALIGN_ERRCNT_EN
  output logic [15:0]         sync_err_cnt,
`endif
  output logic [3:0]          attempts
);

  localparam int MW = $clog2(LOCK_COUNT) + 1;
  localparam int WW = $clog2(SEARCH_TIMEOUT) + 1;
  localparam int UW = $clog2(UNLOCK_COUNT) + 1;

  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [WW-1:0] TO_LAST   = WW'(SEARCH_TIMEOUT - 1);
  localparam logic [UW-1:0] UNL_LAST  = UW'(UNLOCK_COUNT - 1);

  state_t              state_q, state_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic [MW-1:0]       match_cnt_q, match_cnt_d;
  logic [WW-1:0]       word_cnt_q, word_cnt_d;
  logic [UW-1:0]       miss_cnt_q, miss_cnt_d;
  logic [3:0]          attempts_q, attempts_d;
  logic [OFFSET_W-1:0] sweep_q, sweep_d;
  logic [WORD_W-1:0]   cand_sel;
  logic                is_match;

  word_align_shifter u_shifter (
    .clk160         (clk160),
    .rstb           (rstb),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .offset         (offset_q),
    .cand_sel       (cand_sel),
    .data_out       (data_out),
    .data_out_valid (data_out_valid)
  );

  assign is_match = (cand_sel == sync_pattern);

  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    match_cnt_d = match_cnt_q;
    word_cnt_d  = word_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    attempts_d  = attempts_q;
    sweep_d     = sweep_q;
    if (restart || !delay_ready) begin
      state_d    = ST_IDLE;
      attempts_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          attempts_d = '0;
          if (align_mode) begin
            state_d     = ST_SEARCH;
            offset_d    = '0;
            match_cnt_d = '0;
            word_cnt_d  = '0;
            miss_cnt_d  = '0;
            sweep_d     = '0;
          end else begin
            state_d = ST_MANUAL;
          end
        end
        ST_MANUAL: begin
          if (align_mode) state_d = ST_IDLE;
          else            offset_d = manual_offset;
        end
        ST_SEARCH: begin
          if (data_valid) begin
            // Lock takes priority over a timeout landing on the same word.
            if (is_match && match_cnt_q == LOCK_LAST) begin
              state_d     = ST_LOCKED;
              match_cnt_d = '0;
              word_cnt_d  = '0;
              miss_cnt_d  = '0;
            end else if (word_cnt_q == TO_LAST) begin
              offset_d    = offset_q + 1'b1;
              attempts_d  = (attempts_q == 4'(ATTEMPT_MAX)) ? attempts_q : attempts_q + 4'd1;
              match_cnt_d = '0;
              word_cnt_d  = '0;
              sweep_d     = sweep_q + 1'b1;
              if (sweep_q == '1) state_d = ST_FAIL;
            end else begin
              match_cnt_d = is_match ? match_cnt_q + 1'b1 : '0;
              word_cnt_d  = word_cnt_q + 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (track_en && data_valid) begin
            if (is_match) begin
              miss_cnt_d = '0;
            end else if (miss_cnt_q == UNL_LAST) begin
              state_d     = ST_SEARCH;
              match_cnt_d = '0;
              word_cnt_d  = '0;
              miss_cnt_d  = '0;
              sweep_d     = '0;
            end else begin
              miss_cnt_d = miss_cnt_q + 1'b1;
            end
          end
        end
        ST_FAIL: begin
          if (!align_mode) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk160) begin
    if (!rstb) begin
      state_q     <= ST_IDLE;
      offset_q    <= '0;
      match_cnt_q <= '0;
      word_cnt_q  <= '0;
      miss_cnt_q  <= '0;
      attempts_q  <= '0;
      sweep_q     <= '0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      match_cnt_q <= match_cnt_d;
      word_cnt_q  <= word_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      attempts_q  <= attempts_d;
      sweep_q     <= sweep_d;
    end
  end

`ifdef WORD_ALIGN_ERRCNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk160) begin
    if (!rstb) begin
      err_cnt_q <= '0;
    end else if (restart || (state_d == ST_SEARCH && state_q != ST_SEARCH)) begin
      err_cnt_q <= '0;
    end else if (state_q == ST_LOCKED && track_en && data_valid && !is_match &&
                 err_cnt_q != 16'hFFFF) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign sync_err_cnt = err_cnt_q;
`else
  // Error counter is not built in this configuration.
`endif

  assign offset     = offset_q;
  assign aligned    = (state_q == ST_MANUAL) || (state_q == ST_LOCKED);
  assign align_fail = (state_q == ST_FAIL);
  assign attempts   = attempts_q;

endmodule

// File: tb/tb_word_align_ctrl.sv
// Directed bench for word_align_ctrl; aligned data checked through an expected-word queue.
module tb_word_align_ctrl;

  logic       clk160 = 1'b0;
  logic       rstb;
  logic [7:0] data_in;
  logic       data_valid;
  logic       delay_ready;
  logic       align_mode;
  logic [2:0] manual_offset;
  logic [7:0] sync_pattern;
  logic       track_en;
  logic       restart;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic [2:0] offset;
  logic       aligned;
  logic       align_fail;
  logic [3:0] attempts;
`ifdef WORD_ALIGN_ERRCNT_EN
  logic [15:0] sync_err_cnt;
`endif

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] prev_m   = 8'h00;
  logic [7:0] exp_q[$];

  always #3 clk160 = ~clk160;

  word_align_ctrl dut (
    .clk160         (clk160),
    .rstb           (rstb),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .delay_ready    (delay_ready),
    .align_mode     (align_mode),
    .manual_offset  (manual_offset),
    .sync_pattern   (sync_pattern),
    .track_en       (track_en),
    .restart        (restart),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .offset         (offset),
    .aligned        (aligned),
    .align_fail     (align_fail),
`ifdef WORD_ALIGN_ERRCNT_EN
    .sync_err_cnt   (sync_err_cnt),
`endif
    .attempts       (attempts)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference window: offset k selects bits [15-k:8-k] of {prev, cur}.
  function automatic logic [7:0] win(input logic [7:0] p, input logic [7:0] w, input int k);
    logic [15:0] c;
    c = {p, w} << k;
    return c[15:8];
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk160);
      #1;
    end
  endtask

  task automatic drive(input logic [7:0] w, input bit chk, input logic [7:0] exp);
    logic [7:0] e;
    data_in    = w;
    data_valid = 1'b1;
    if (chk) exp_q.push_back(exp);
    @(posedge clk160);
    #1;
    prev_m     = w;
    data_valid = 1'b0;
    if (chk) begin
      check("dout_vld", 16'(data_out_valid), 16'd1);
      e = exp_q.pop_front();
      check("dout", 16'(data_out), 16'(e));
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk160);
    #1;
    restart = 1'b0;
  endtask

  initial begin
    rstb = 1'b0; data_in = 8'h00; data_valid = 1'b0; delay_ready = 1'b0;
    align_mode = 1'b1; manual_offset = 3'd0; sync_pattern = 8'hAC;
    track_en = 1'b1; restart = 1'b0;
    tick(3);
    check("rst_dout", 16'(data_out), 16'd0);
    check("rst_dvld", 16'(data_out_valid), 16'd0);
    check("rst_offset", 16'(offset), 16'd0);
    check("rst_aligned", 16'(aligned), 16'd0);
    check("rst_fail", 16'(align_fail), 16'd0);
    check("rst_attempts", 16'(attempts), 16'd0);

    // Auto search: 0x95 rotated left by 3 gives 0xAC.
    rstb = 1'b1; delay_ready = 1'b1;
    tick(2);
    for (int i = 0; i < 207; i++) drive(8'h95, 1'b0, 8'h00);
    check("lock_early_aligned", 16'(aligned), 16'd0);
    drive(8'h95, 1'b0, 8'h00);
    check("lock_aligned", 16'(aligned), 16'd1);
    check("lock_offset", 16'(offset), 16'd3);
    check("lock_attempts", 16'(attempts), 16'd3);
    for (int i = 0; i < 6; i++) drive(8'h95, 1'b1, 8'hAC);

    // 0x15 mismatches on its own and after 0x95, but {0x15,0x95} at offset 3 is 0xAC.
    for (int i = 0; i < 3; i++) drive(8'h15, 1'b0, 8'h00);
    check("miss3_aligned", 16'(aligned), 16'd1);
    drive(8'h15, 1'b0, 8'h00);
    check("unlock_aligned", 16'(aligned), 16'd0);
    check("unlock_offset", 16'(offset), 16'd3);
    for (int i = 0; i < 15; i++) drive(8'h95, 1'b0, 8'h00);
    check("relock_early", 16'(aligned), 16'd0);
    drive(8'h95, 1'b0, 8'h00);
    check("relock_aligned", 16'(aligned), 16'd1);
    check("relock_offset", 16'(offset), 16'd3);
    check("relock_attempts", 16'(attempts), 16'd3);

    // Three misses then a match, repeated, plus one stray miss: ten misses, never unlocks.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) drive(8'h15, 1'b0, 8'h00);
      drive(8'h95, 1'b1, 8'hAC);
      check("3bad1good_aligned", 16'(aligned), 16'd1);
    end
    drive(8'h15, 1'b0, 8'h00);
    drive(8'h95, 1'b1, 8'hAC);
    check("10miss_aligned", 16'(aligned), 16'd1);
`ifdef WORD_ALIGN_ERRCNT_EN
    check("errcnt_10", sync_err_cnt, 16'd10);
`endif

    // Misses are ignored while training is off.
    track_en = 1'b0;
    for (int i = 0; i < 6; i++) drive(8'h15, 1'b0, 8'h00);
    check("notrack_aligned", 16'(aligned), 16'd1);
    drive(8'h95, 1'b1, 8'hAC);
    track_en = 1'b1;
`ifdef WORD_ALIGN_ERRCNT_EN
    check("errcnt_notrack", sync_err_cnt, 16'd10);
`endif

    // Manual offset.
    align_mode = 1'b0; manual_offset = 3'd5;
    pulse_restart();
    check("restart_aligned", 16'(aligned), 16'd0);
`ifdef WORD_ALIGN_ERRCNT_EN
    check("errcnt_restart", sync_err_cnt, 16'd0);
`endif
    tick(3);
    check("man_offset", 16'(offset), 16'd5);
    check("man_aligned", 16'(aligned), 16'd1);
    drive(8'hF0, 1'b1, win(prev_m, 8'hF0, 5));
    drive(8'h0F, 1'b1, 8'h01);
    manual_offset = 3'd2;
    tick(2);
    check("man_offset2", 16'(offset), 16'd2);
    drive(8'h0F, 1'b1, win(prev_m, 8'h0F, 2));

    // Full sweep with no pattern.
    align_mode = 1'b1;
    tick(3);
    check("sweep_start_offset", 16'(offset), 16'd0);
    for (int i = 0; i < 511; i++) drive(8'($urandom_range(0, 255)), 1'b0, 8'h00);
    check("fail_early", 16'(align_fail), 16'd0);
    drive(8'($urandom_range(0, 255)), 1'b0, 8'h00);
    check("fail_flag", 16'(align_fail), 16'd1);
    check("fail_attempts", 16'(attempts), 16'd8);
    check("fail_aligned", 16'(aligned), 16'd0);
    pulse_restart();
    check("fail_clr", 16'(align_fail), 16'd0);
    check("fail_clr_attempts", 16'(attempts), 16'd0);
    tick(1);
    check("research_offset", 16'(offset), 16'd0);

    // delay_ready drop together with restart mid-search.
    for (int i = 0; i < 70; i++) drive(8'($urandom_range(0, 255)), 1'b0, 8'h00);
    check("mid_attempts", 16'(attempts), 16'd1);
    check("mid_offset", 16'(offset), 16'd1);
    restart = 1'b1; delay_ready = 1'b0;
    tick(1);
    restart = 1'b0;
    check("drop_aligned", 16'(aligned), 16'd0);
    check("drop_attempts", 16'(attempts), 16'd0);
    tick(2);
    delay_ready = 1'b1;
    tick(2);
    check("resume_offset", 16'(offset), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
